// File: rtl/mem_access_master_pkg.sv
// Shared constants, FSM encoding and pipeline tag layout for mem_access_master.
package mem_access_master_pkg;

   localparam int unsigned ADDR_BITS     = 8;
   localparam int unsigned DATA_BITS     = 8;
   localparam int unsigned ROM_SIZE      = 64;
   localparam int unsigned MEM_SIZE      = 256;
   localparam int unsigned LEN_BITS      = 4;
   // One extra bit so that address overflow is seen as out of range, never wrapped.
   localparam int unsigned ADDR_EXT_BITS = ADDR_BITS + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Per-beat tag travelling alongside the memory access.
   typedef struct packed {
      logic valid;
      logic is_write;
      logic is_last;
      logic range_err;
   } beat_tag_t;

   // True when a beat address lies outside the memory.
   function automatic logic addr_out_of_range(input logic [ADDR_EXT_BITS-1:0] a);
      return (a >= ADDR_EXT_BITS'(MEM_SIZE));
   endfunction

endpackage

// File: rtl/mem_access_master_if.sv
// Request, response and memory-side signals of mem_access_master.
interface mem_access_master_if;
   import mem_access_master_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [ADDR_BITS-1:0] req_addr;
   logic [LEN_BITS-1:0]  req_len;
   logic [DATA_BITS-1:0] req_wdata;

   logic                 rsp_valid;
   logic [DATA_BITS-1:0] rsp_rdata;
   logic                 rsp_err;
   logic                 rsp_last;

   logic [ADDR_BITS-1:0] mem_addr;
   logic [DATA_BITS-1:0] mem_wdata;
   logic                 mem_cs;
   logic                 mem_we;
   logic [DATA_BITS-1:0] mem_rdata;
   logic                 mem_error;

   // View of the access master itself.
   modport master (
      input  req_valid, req_we, req_addr, req_len, req_wdata,
      input  mem_rdata, mem_error,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_last,
      output mem_addr, mem_wdata, mem_cs, mem_we
   );

   // View of the surrounding requester and memory.
   modport slave (
      output req_valid, req_we, req_addr, req_len, req_wdata,
      output mem_rdata, mem_error,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_last,
      input  mem_addr, mem_wdata, mem_cs, mem_we
   );

endinterface

// File: rtl/mem_rsp_pipe.sv
// Two-stage beat tag shift register aligned with memory latency, plus the
// registered response stage.
module mem_rsp_pipe
   import mem_access_master_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RESET,
   input  beat_tag_t            issue_tag,
   input  logic [DATA_BITS-1:0] mem_rdata,
   input  logic                 mem_error,
   output logic                 busy_c,
   output logic                 rsp_valid,
   output logic [DATA_BITS-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 rsp_last
);

   beat_tag_t stage0;
   beat_tag_t stage1;

   // Any beat still waiting for its memory result.
   assign busy_c = stage0.valid | stage1.valid;

   // Shift tags; stage1 lines up with the memory output, which is captured here.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stage0    <= '0;
         stage1    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         rsp_last  <= 1'b0;
      end else begin
         stage0    <= issue_tag;
         stage1    <= stage0;
         rsp_valid <= stage1.valid;
         if (stage1.valid) begin
            rsp_last <= stage1.is_last;
            // mem_error is sticky, so it is only meaningful right after an issued write.
            rsp_err  <= stage1.range_err | (stage1.is_write & mem_error);
            rsp_rdata <= (!stage1.is_write && !stage1.range_err) ? mem_rdata : '0;
         end else begin
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_access_master.sv
// Memory access initiator: accepts single writes and incrementing read bursts,
// issues one memory access per cycle and returns one response per beat.
module mem_access_master
   import mem_access_master_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RESET,
   mem_access_master_if.master  bus
);

   state_t                     state, state_nxt;
   logic [ADDR_EXT_BITS-1:0]   beat_addr, beat_addr_nxt;
   logic [LEN_BITS-1:0]        remain, remain_nxt;
   logic                       cur_last, cur_last_nxt;
   logic                       we_q, we_nxt;
   logic [DATA_BITS-1:0]       wdata_q, wdata_nxt;

   logic                       req_ready_q, req_ready_nxt;
   logic                       mem_cs_q, mem_cs_nxt;
   logic                       mem_we_q, mem_we_nxt;
   logic [ADDR_BITS-1:0]       mem_addr_q, mem_addr_nxt;
   logic [DATA_BITS-1:0]       mem_wdata_q, mem_wdata_nxt;

   logic                       accept_c;
   logic                       issue_go_c;
   logic [ADDR_EXT_BITS-1:0]   issue_addr_c;
   logic [LEN_BITS-1:0]        issue_rem_c;
   logic                       issue_we_c;
   logic                       issue_rerr_c;
   logic                       issue_last_c;
   beat_tag_t                  issue_tag_c;
   logic                       pipe_busy_c;

   assign accept_c = bus.req_valid & req_ready_q;

   // State, burst bookkeeping and registered outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= IDLE;
         beat_addr   <= '0;
         remain      <= '0;
         cur_last    <= 1'b0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         req_ready_q <= 1'b1;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state       <= state_nxt;
         beat_addr   <= beat_addr_nxt;
         remain      <= remain_nxt;
         cur_last    <= cur_last_nxt;
         we_q        <= we_nxt;
         wdata_q     <= wdata_nxt;
         req_ready_q <= req_ready_nxt;
         mem_cs_q    <= mem_cs_nxt;
         mem_we_q    <= mem_we_nxt;
         mem_addr_q  <= mem_addr_nxt;
         mem_wdata_q <= mem_wdata_nxt;
      end
   end

   // Next state and the beat to drive to memory in the following cycle.
   always_comb begin
      state_nxt     = state;
      beat_addr_nxt = beat_addr;
      remain_nxt    = remain;
      cur_last_nxt  = cur_last;
      we_nxt        = we_q;
      wdata_nxt     = wdata_q;
      mem_cs_nxt    = 1'b0;
      mem_we_nxt    = 1'b0;
      mem_addr_nxt  = mem_addr_q;
      mem_wdata_nxt = mem_wdata_q;
      issue_go_c    = 1'b0;
      issue_addr_c  = '0;
      issue_rem_c   = '0;
      issue_we_c    = 1'b0;
      issue_rerr_c  = 1'b0;
      issue_last_c  = 1'b0;
      issue_tag_c   = '0;

      case (state)
         IDLE: begin
            if (accept_c) begin
               state_nxt    = ISSUE;
               we_nxt       = bus.req_we;
               wdata_nxt    = bus.req_wdata;
               issue_go_c   = 1'b1;
               issue_addr_c = {1'b0, bus.req_addr};
               issue_rem_c  = bus.req_we ? '0 : bus.req_len;
               issue_we_c   = bus.req_we;
            end
         end
         ISSUE: begin
            if (cur_last) begin
               state_nxt = DRAIN;
            end else begin
               issue_go_c   = 1'b1;
               issue_addr_c = beat_addr + ADDR_EXT_BITS'(1);
               issue_rem_c  = remain - LEN_BITS'(1);
               issue_we_c   = we_q;
            end
         end
         DRAIN: begin
            if (!pipe_busy_c) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // An out-of-range beat is never driven and ends the burst.
      if (issue_go_c) begin
         issue_rerr_c  = addr_out_of_range(issue_addr_c);
         issue_last_c  = (issue_rem_c == '0) | issue_rerr_c;
         issue_tag_c   = '{valid: 1'b1, is_write: issue_we_c,
                           is_last: issue_last_c, range_err: issue_rerr_c};
         beat_addr_nxt = issue_addr_c;
         remain_nxt    = issue_rem_c;
         cur_last_nxt  = issue_last_c;
         mem_cs_nxt    = !issue_rerr_c;
         mem_we_nxt    = issue_we_c & !issue_rerr_c;
         mem_addr_nxt  = ADDR_BITS'(issue_addr_c);
         mem_wdata_nxt = wdata_nxt;
      end

      req_ready_nxt = (state_nxt == IDLE);
   end

   assign bus.req_ready = req_ready_q;
   assign bus.mem_cs    = mem_cs_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   // Tag pipeline and response register.
   mem_rsp_pipe u_rsp_pipe (
      .CLK       (CLK),
      .RESET     (RESET),
      .issue_tag (issue_tag_c),
      .mem_rdata (bus.mem_rdata),
      .mem_error (bus.mem_error),
      .busy_c    (pipe_busy_c),
      .rsp_valid (bus.rsp_valid),
      .rsp_rdata (bus.rsp_rdata),
      .rsp_err   (bus.rsp_err),
      .rsp_last  (bus.rsp_last)
   );

endmodule

// File: tb/tb_mem_access_master.sv
// Directed plus random stimulus for mem_access_master against a behavioural
// memory and a per-request expected-response model.
module tb_mem_access_master;
   import mem_access_master_pkg::*;

   logic CLK = 1'b0;
   logic RESET;
   int   total = 0;
   int   bad   = 0;

   always #5 CLK = ~CLK;

   mem_access_master_if bus ();

   mem_access_master dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   // Power-on contents of the unified memory (ROM and RAM alike).
   function automatic logic [7:0] init_val(input int a);
      if (a == 5) return 8'hA5;
      return 8'(a * 37 + 11);
   endfunction

   // Behavioural memory: registered o_dat, sticky ERROR set by ROM writes.
   logic [7:0] mem_arr [256];
   logic       written [256];
   always @(posedge CLK) begin
      if (RESET) begin
         bus.mem_rdata <= '0;
         bus.mem_error <= 1'b0;
      end else if (bus.mem_cs) begin
         if (bus.mem_we) begin
            if (int'(bus.mem_addr) < int'(ROM_SIZE)) begin
               bus.mem_error <= 1'b1;
            end else begin
               mem_arr[bus.mem_addr] <= bus.mem_wdata;
               written[bus.mem_addr] <= 1'b1;
               bus.mem_error         <= 1'b0;
            end
         end else begin
            bus.mem_rdata <= (written[bus.mem_addr] === 1'b1) ? mem_arr[bus.mem_addr]
                                                              : init_val(int'(bus.mem_addr));
         end
      end
   end

   logic [7:0] ref_mem [256];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Issue one request and check every cycle until req_ready returns.
   task automatic run_req(input logic we, input int addr, input int len, input logic [7:0] wd);
      int         nb;
      int         n;
      int         n_issue;
      logic [7:0] exp_dat [$];
      logic       exp_err [$];
      nb      = we ? 1 : len + 1;
      n_issue = 0;
      for (int k = 0; k < nb; k++) begin
         int a;
         a = addr + k;
         if (a >= int'(MEM_SIZE)) begin
            exp_dat.push_back(8'h00);
            exp_err.push_back(1'b1);
            break;
         end
         n_issue++;
         if (we) begin
            exp_dat.push_back(8'h00);
            exp_err.push_back(a < int'(ROM_SIZE));
            if (a >= int'(ROM_SIZE)) ref_mem[a] = wd;
         end else begin
            exp_dat.push_back(ref_mem[a]);
            exp_err.push_back(1'b0);
         end
      end
      n = exp_dat.size();

      chk("ready_before_req", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = 8'(addr);
      bus.req_len   = 4'(len);
      bus.req_wdata = wd;
      step();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom);
      bus.req_addr  = 8'($urandom);
      bus.req_len   = 4'($urandom);
      bus.req_wdata = 8'($urandom);

      for (int c = 1; c <= n + 3; c++) begin
         logic issue;
         logic rv;
         issue = (c - 1) < n_issue;
         rv    = (c >= 3) && ((c - 3) < n);
         chk("mem_cs", 32'(bus.mem_cs), 32'(issue));
         if (issue) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(addr + c - 1));
            chk("mem_we", 32'(bus.mem_we), 32'(we));
            if (we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
         end
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
         if (rv) begin
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_dat[c-3]));
            chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err[c-3]));
            chk("rsp_last", 32'(bus.rsp_last), 32'((c - 3) == (n - 1)));
         end
         chk("req_ready", 32'(bus.req_ready), 32'(c == n + 3));
         if (c < n + 3) step();
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
      chk({tag, "_rsp_last"},  32'(bus.rsp_last),  32'd0);
      chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
      chk({tag, "_mem_cs"},    32'(bus.mem_cs),    32'd0);
      chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
      chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
      chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      RESET         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.req_wdata = '0;
      step();
      step();
      step();
      chk_reset_state("por");
      RESET = 1'b0;
      step();

      // Single ROM read
      run_req(1'b0, 8'h05, 0, 8'h00);
      // RAM write then read back
      run_req(1'b1, 8'h80, 0, 8'h3C);
      run_req(1'b0, 8'h80, 0, 8'h00);
      // ROM write is rejected by memory, contents unchanged
      run_req(1'b1, 8'h10, 0, 8'h11);
      run_req(1'b0, 8'h10, 0, 8'h00);
      // ROM/RAM boundary writes and a clean write after a sticky error
      run_req(1'b1, 8'h3F, 0, 8'h77);
      run_req(1'b1, 8'h40, 0, 8'h99);
      // Four-beat burst
      run_req(1'b0, 8'h40, 3, 8'h00);
      // Burst running off the end of memory
      run_req(1'b0, 8'hFE, 3, 8'h00);
      // Full-length burst ending exactly at the last word
      run_req(1'b0, 8'hF0, 15, 8'h00);
      // Burst starting on the last word
      run_req(1'b0, 8'hFF, 15, 8'h00);

      // Reset in the middle of an 8-beat burst
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 8'h20;
      bus.req_len   = 4'd7;
      step();
      bus.req_valid = 1'b0;
      step();
      step();
      step();
      RESET = 1'b1;
      step();
      step();
      chk_reset_state("mid_reset");
      RESET = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("post_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("post_reset_mem_cs", 32'(bus.mem_cs), 32'd0);
         step();
      end

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         logic we;
         int   addr;
         we   = ($urandom_range(0, 2) == 0);
         addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(236, 255))
                                            : int'($urandom_range(0, 255));
         run_req(we, addr, int'($urandom_range(0, 15)), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
